signed_divider_64: RTL
======================

SIGNED_DIVIDER_64 -- requirements
Module: signed_divider_64

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 64, operand and result width in bits.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start_i  input  1  request; sampled only in IDLE.
REQ-006 Port: a_i  input  WIDTH  signed dividend (two's complement).
REQ-007 Port: b_i  input  WIDTH  signed divisor (two's complement).
REQ-008 Port: busy_o  output  1  high from the cycle after acceptance until done_o cycle inclusive.
REQ-009 Port: done_o  output  1  one-cycle pulse, results valid.
REQ-010 Port: quotient_o  output  WIDTH  signed quotient.
REQ-011 Port: remainder_o  output  WIDTH  signed remainder.
REQ-012 Port: div_zero_o  output  1  last operation had b_i == 0.
REQ-013 Port: overflow_o  output  1  last operation was -2^(WIDTH-1) / -1.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX, DONE.
REQ-015 IDLE with start_i=1: capture a_i, b_i, and their signs; load |a|, |b| (unsigned, WIDTH bits); clear step counter; go to CALC.
REQ-016 CALC: one restoring step per cycle (shift {rem,dividend} left 1; if rem >= |b|, subtract and set quotient bit); exactly WIDTH cycles, then FIX.
REQ-017 FIX: quotient negated if sign(a) XOR sign(b); remainder negated if sign(a); go to DONE.
REQ-018 DONE: register results to outputs, pulse done_o for one cycle, return to IDLE.
REQ-019 Latency: done_o SHALL be high exactly WIDTH+3 cycles after the start_i acceptance edge; next start_i is accepted in the cycle after done_o.
REQ-020 Division SHALL truncate toward zero; |remainder| < |divisor|; remainder sign equals dividend sign (or zero).
REQ-021 b_i == 0: quotient_o = all ones (-1), remainder_o = a_i, div_zero_o = 1, overflow_o = 0.
REQ-022 a_i = -2^(WIDTH-1), b_i = -1: quotient_o = -2^(WIDTH-1), remainder_o = 0, overflow_o = 1, div_zero_o = 0.
REQ-023 start_i while busy_o=1 SHALL be ignored; captured operands SHALL NOT change.
REQ-024 quotient_o, remainder_o, div_zero_o, overflow_o SHALL hold their values from done_o until the next done_o.
REQ-025 Operand changes on a_i/b_i after acceptance SHALL NOT affect the result.

Reset
REQ-026 rst asserted SHALL immediately force IDLE, busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_zero_o=0, overflow_o=0.
REQ-027 rst mid-operation SHALL abort; no done_o SHALL follow until a new start_i is accepted after rst deasserts.

Configuration
REQ-028 Macro SIGNED_DIV_FAST_ZERO_EN defined: b_i == 0 SHALL bypass CALC and FIX (IDLE -> DONE), done_o 1 cycle after acceptance.
REQ-029 Macro undefined: b_i == 0 SHALL take the full WIDTH+3 cycle path; result values per REQ-021 unchanged.

Verification
REQ-030 a=1000, b=7, start pulse -> done_o exactly 67 cycles later; quotient 142, remainder 6, flags 0.
REQ-031 Sign matrix: -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1; -1512/42 -> q=-36, r=0.
REQ-032 a=-2^63, b=-1 -> q=-2^63, r=0, overflow_o=1; a=-2^63, b=1 -> q=-2^63, r=0, overflow_o=0.
REQ-033 a=12345, b=0 -> q=0xFFFF_FFFF_FFFF_FFFF, r=12345, div_zero_o=1; done_o 1 cycle after acceptance with macro defined, 67 cycles without.
REQ-034 Accept a=100, b=3; drive start_i=1 with a=9, b=9 at cycle 10 -> ignored, result q=33, r=1; then rst asserted at cycle 30 of a second operation -> all outputs 0 immediately, no done_o.
REQ-035 Random signed operands (>=1000 pairs) -> a == q*b + r and REQ-020 hold, cross-checked against the signed multiplier product.

Source files
------------

// File: rtl/signed_divider_64.sv
// -----------------------------------------------------------------------------
// signed_divider_64
//
// Purpose:
//   Multi-cycle signed integer divider (two's complement, truncating toward
//   zero). Magnitudes are divided by a restoring shift/subtract loop, one
//   quotient bit per cycle. The signs are then applied in a single fix-up
//   cycle. Division by zero and the single overflow case (most negative
//   value divided by -1) are flagged, and both give defined results.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start_i      request, sampled only while idle and not busy
//   a_i          signed dividend (WIDTH bits)
//   b_i          signed divisor  (WIDTH bits)
//   busy_o       high from the cycle after acceptance through the done cycle
//   done_o       one-cycle pulse: results below are valid
//   quotient_o   signed quotient, held until the next done_o
//   remainder_o  signed remainder (sign of dividend), held until next done_o
//   div_zero_o   last operation had a zero divisor
//   overflow_o   last operation was -2^(WIDTH-1) / -1
//
// Configuration:
//   SIGNED_DIV_FAST_ZERO_EN  when defined, a zero divisor skips the iterative
//                            loop and the result is published on the
//                            acceptance edge. When undefined, a zero divisor
//                            takes the full-length path. The result values
//                            are the same in both builds.
//
// WIDTH must be at least 2.
// -----------------------------------------------------------------------------
module signed_divider_64 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o,
   output logic             overflow_o
);

   localparam int               CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef SIGNED_DIV_FAST_ZERO_EN
   localparam logic FAST_ZERO = 1'b1;
`else
   localparam logic FAST_ZERO = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Two's complement negation.
   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return ~x + ONE;
   endfunction

   // Magnitude as an unsigned WIDTH-bit value (MIN_VAL maps to 2^(WIDTH-1)).
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? negate(x) : x;
   endfunction

   state_t           state_r, next_state_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_r;        // raw dividend, returned as remainder on /0
   logic [WIDTH-1:0] abs_b_r;
   logic [WIDTH-1:0] dvd_r;      // dividend shifts out, quotient bits shift in
   logic [WIDTH-1:0] rem_r;
   logic             sign_a_r;
   logic             sign_q_r;
   logic             div_zero_r;
   logic             overflow_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] q_out_r;
   logic [WIDTH-1:0] r_out_r;
   logic             dz_out_r;
   logic             ov_out_r;

   logic             accept_s;
   logic             bypass_s;
   logic [WIDTH-1:0] rem_shift_s;
   logic [WIDTH-1:0] rem_next_s;
   logic [WIDTH-1:0] dvd_next_s;
   logic             fits_s;

   // Request qualification: only an idle, non-busy divider accepts a start.
   always_comb begin
      accept_s = 1'b0;
      bypass_s = 1'b0;
      if ((state_r == IDLE) && start_i && !busy_r) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if (FAST_ZERO && (b_i == ZERO)) begin
         bypass_s = 1'b1;
      end else begin
         bypass_s = 1'b0;
      end
   end

   // One restoring step. The partial remainder is always below |b| <= 2^(W-1)
   // (or, for a zero divisor, holds fewer than W dividend bits), so its MSB
   // is zero before every shift and a W-bit compare suffices.
   always_comb begin
      rem_shift_s = {rem_r[WIDTH-2:0], dvd_r[WIDTH-1]};
      rem_next_s  = rem_shift_s;
      fits_s      = 1'b0;
      if (rem_shift_s >= abs_b_r) begin
         rem_next_s = rem_shift_s - abs_b_r;
         fits_s     = 1'b1;
      end else begin
         rem_next_s = rem_shift_s;
         fits_s     = 1'b0;
      end
      dvd_next_s = {dvd_r[WIDTH-2:0], fits_s};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s && bypass_s) begin
               next_state_s = DONE;
            end else if (accept_s) begin
               next_state_s = CALC;
            end else begin
               next_state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == LAST_STEP) begin
               next_state_s = FIX;
            end else begin
               next_state_s = CALC;
            end
         end
         FIX:     next_state_s = DONE;
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, sign fix-up and result publication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r      <= CNT_ZERO;
         a_r        <= ZERO;
         abs_b_r    <= ZERO;
         dvd_r      <= ZERO;
         rem_r      <= ZERO;
         sign_a_r   <= 1'b0;
         sign_q_r   <= 1'b0;
         div_zero_r <= 1'b0;
         overflow_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         q_out_r    <= ZERO;
         r_out_r    <= ZERO;
         dz_out_r   <= 1'b0;
         ov_out_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         // busy drops on the edge that ends the done cycle
         if (done_r) begin
            busy_r <= 1'b0;
         end
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r        <= a_i;
                  abs_b_r    <= magnitude(b_i);
                  dvd_r      <= magnitude(a_i);
                  rem_r      <= ZERO;
                  sign_a_r   <= a_i[WIDTH-1];
                  sign_q_r   <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                  div_zero_r <= (b_i == ZERO);
                  overflow_r <= (a_i == MIN_VAL) && (b_i == ALL_ONES);
                  cnt_r      <= CNT_ZERO;
                  busy_r     <= 1'b1;
                  // fast zero-divisor path publishes on the acceptance edge
                  if (bypass_s) begin
                     q_out_r  <= ALL_ONES;
                     r_out_r  <= a_i;
                     dz_out_r <= 1'b1;
                     ov_out_r <= 1'b0;
                     done_r   <= 1'b1;
                  end
               end
            end
            CALC: begin
               rem_r <= rem_next_s;
               dvd_r <= dvd_next_s;
               cnt_r <= cnt_r + CNT_ONE;
            end
            FIX: begin
               if (sign_q_r) begin
                  dvd_r <= negate(dvd_r);
               end
               if (sign_a_r) begin
                  rem_r <= negate(rem_r);
               end
            end
            DONE: begin
               // a bypassed zero-divide already published its result
               if (!(FAST_ZERO && div_zero_r)) begin
                  q_out_r  <= div_zero_r ? ALL_ONES : dvd_r;
                  r_out_r  <= div_zero_r ? a_r : rem_r;
                  dz_out_r <= div_zero_r;
                  ov_out_r <= overflow_r;
                  done_r   <= 1'b1;
               end
            end
            default: done_r <= 1'b0;
         endcase
      end
   end

   assign busy_o      = busy_r;
   assign done_o      = done_r;
   assign quotient_o  = q_out_r;
   assign remainder_o = r_out_r;
   assign div_zero_o  = dz_out_r;
   assign overflow_o  = ov_out_r;

endmodule
